// File: rtl/sipo_pkg.sv
// Shared types and line levels for the serial frame receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } rx_state_t;

  localparam logic SIPO_IDLE_LVL  = 1'b1;
  localparam logic SIPO_START_LVL = 1'b0;
  localparam logic SIPO_STOP_LVL  = 1'b1;

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register; a load wins over a drain in the same cycle.
module sipo_hold_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // NOTE: the data register is reset as well, because the idle output word is observable and must read 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial-in, parallel-out frame receiver: start, N data bits MSB first, optional even parity, stop.
module sipo_frame_rx
  import sipo_pkg::*;
#(
  parameter int N      = 8,
  parameter bit PARITY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_en,
  input  logic         sin,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic          perr_q, perr_d;
  logic          frame_err_q, overrun_q;
  logic          good_frame, bad_stop, load;

  // NOTE: every variable gets its default first so that no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    good_frame = 1'b0;
    bad_stop   = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (sin == SIPO_START_LVL) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d = {shreg_q[N-2:0], sin};
          if (cnt_q == CNT_LAST) state_d = PARITY ? PAR : STOP;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        PAR: begin
          perr_d  = PARITY ? (^shreg_q ^ sin) : 1'b0;
          state_d = STOP;
        end
        STOP: begin
          if (sin == SIPO_STOP_LVL) good_frame = 1'b1;
          else                      bad_stop   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A full register that is being drained this cycle can still take the new word.
  assign load = good_frame & (~out_valid | out_ready);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      perr_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      perr_q      <= PARITY ? perr_d : 1'b0;
      frame_err_q <= bad_stop;
      overrun_q   <= good_frame & ~load;
    end
  end

  sipo_hold_reg #(
    .W (N + 1)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_data_i ({perr_q, shreg_q}),
    .ready_i     (out_ready),
    .valid_o     (out_valid),
    .data_o      ({parity_err, out_data})
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench: PARITY=1 receiver for framing/overrun/reset cases, PARITY=0 receiver for back-to-back frames.
module tb_sipo_frame_rx;
  import sipo_pkg::*;

  logic       clk, rst, bit_en, sin, use_b;
  logic       bit_en_a, bit_en_b;
  logic       ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;
  int         checks, errors;

  assign bit_en_a = bit_en & ~use_b;
  assign bit_en_b = bit_en & use_b;

  sipo_frame_rx #(.N(8), .PARITY(1'b1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en_a),
    .sin        (sin),
    .out_data   (data_a),
    .out_valid  (valid_a),
    .out_ready  (ready_a),
    .parity_err (perr_a),
    .frame_err  (ferr_a),
    .overrun    (ovr_a)
  );

  sipo_frame_rx #(.N(8), .PARITY(1'b0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en_b),
    .sin        (sin),
    .out_data   (data_b),
    .out_valid  (valid_b),
    .out_ready  (ready_b),
    .parity_err (perr_b),
    .frame_err  (ferr_b),
    .overrun    (ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling posedge.
  task automatic strobe(input logic b);
    bit_en = 1'b1;
    sin    = b;
    @(negedge clk);
    bit_en = 1'b0;
    sin    = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par,
                            input logic stop, input logic rdy_stop_a);
    strobe(1'b0);
    for (int i = 7; i >= 0; i--) strobe(d[i]);
    if (par_en) strobe(par);
    if (rdy_stop_a) ready_a = 1'b1;
    strobe(stop);
    if (rdy_stop_a) ready_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bit_en  = 1'b0;
    sin     = 1'b1;
    use_b   = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_data",  32'(data_a),  32'h00);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_perr",  32'(perr_a),  32'h0);
    check("rst_ferr",  32'(ferr_a),  32'h0);
    check("rst_ovr",   32'(ovr_a),   32'h0);
    check("rst_state", 32'(dut_a.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;

    // Good frame 0xA5, even parity bit 0.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("a5_valid", 32'(valid_a), 32'h1);
    check("a5_data",  32'(data_a),  32'hA5);
    check("a5_perr",  32'(perr_a),  32'h0);
    check("a5_ferr",  32'(ferr_a),  32'h0);
    @(negedge clk);
    check("a5_drain", 32'(valid_a), 32'h0);

    // Same frame with a wrong parity bit, held until drained.
    ready_a = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    check("pe_data", 32'(data_a), 32'hA5);
    check("pe_perr", 32'(perr_a), 32'h1);
    @(negedge clk);
    check("pe_hold", 32'(valid_a), 32'h1);
    ready_a = 1'b1;
    @(negedge clk);
    check("pe_drain", 32'(valid_a), 32'h0);

    // Framing error on 0x3C, then a clean 0x01.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fe_pulse", 32'(ferr_a),  32'h1);
    check("fe_valid", 32'(valid_a), 32'h0);
    check("fe_state", 32'(dut_a.state_q), 32'(IDLE));
    @(negedge clk);
    check("fe_end", 32'(ferr_a), 32'h0);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    check("fe_next_data",  32'(data_a),  32'h01);
    check("fe_next_valid", 32'(valid_a), 32'h1);
    check("fe_next_perr",  32'(perr_a),  32'h0);
    @(negedge clk);

    // Overrun, then same-cycle refill.
    ready_a = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ov_first", 32'(data_a), 32'h11);
    check("ov_none",  32'(ovr_a),  32'h0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ov_pulse", 32'(ovr_a),   32'h1);
    check("ov_keep",  32'(data_a),  32'h11);
    check("ov_valid", 32'(valid_a), 32'h1);
    @(negedge clk);
    check("ov_end", 32'(ovr_a), 32'h0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b1);
    check("rf_data",  32'(data_a),  32'h22);
    check("rf_valid", 32'(valid_a), 32'h1);
    check("rf_ovr",   32'(ovr_a),   32'h0);
    ready_a = 1'b1;
    @(negedge clk);
    check("rf_drain", 32'(valid_a), 32'h0);

    // Reset with a held word and a frame in progress.
    ready_a = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    check("mr_held", 32'(valid_a), 32'h1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    #2 rst = 1'b0;
    #1;
    check("mr_valid", 32'(valid_a), 32'h0);
    check("mr_data",  32'(data_a),  32'h00);
    check("mr_perr",  32'(perr_a),  32'h0);
    check("mr_state", 32'(dut_a.state_q), 32'(IDLE));
    @(negedge clk);
    rst     = 1'b1;
    ready_a = 1'b1;
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    check("mr_ff_data",  32'(data_a),  32'hFF);
    check("mr_ff_valid", 32'(valid_a), 32'h1);
    check("mr_ff_perr",  32'(perr_a),  32'h0);
    @(negedge clk);

    // No parity, strobes on every cycle, frames back to back.
    use_b = 1'b1;
    send_frame(8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    check("np_80_valid", 32'(valid_b), 32'h1);
    check("np_80_data",  32'(data_b),  32'h80);
    check("np_80_perr",  32'(perr_b),  32'h0);
    send_frame(8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    check("np_7f_valid", 32'(valid_b), 32'h1);
    check("np_7f_data",  32'(data_b),  32'h7F);
    check("np_7f_perr",  32'(perr_b),  32'h0);
    check("np_ferr",     32'(ferr_b),  32'h0);
    check("np_ovr",      32'(ovr_b),   32'h0);
    @(negedge clk);
    check("np_drain", 32'(valid_b), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
